dmem_arb: RTL and testbench

Arbiter that shares the core's single data SRAM port between the core load/store path and a host/loader port (debug, test loader or DMA). It sits between the core's `dat_*` outputs and the SRAM1 macro. The core has absolute priority because its LSU cannot stall. Host requests are captured in a one-entry buffer and issued in the first cycle the core leaves the SRAM idle. A saturating wait counter flags host starvation.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_arb.sv | 119 +++++++++++
 tb/tb_dmem_arb.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data SRAM arbiter.
// Request bundle widths follow the default SRAM geometry.
package dmem_arb_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;
  localparam int BW_DEF = DW_DEF / 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_st_t;

  typedef struct packed {
    logic [AW_DEF-1:0] a;
    logic [BW_DEF-1:0] we;
    logic [DW_DEF-1:0] wd;
    logic [BW_DEF-1:0] re;
  } req_t;

endpackage

// File: rtl/dmem_arb.sv
// Data SRAM port arbiter: core has absolute priority,
// host requests wait in a one-entry buffer.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 15
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [AW-1:0]   c_a,
  input  logic [DW/8-1:0] c_we,
  input  logic [DW-1:0]   c_wd,
  input  logic [DW/8-1:0] c_re,
  output logic [DW-1:0]   c_rd,
  input  logic            h_vld,
  output logic            h_rdy,
  input  logic [AW-1:0]   h_a,
  input  logic [DW/8-1:0] h_we,
  input  logic [DW-1:0]   h_wd,
  input  logic [DW/8-1:0] h_re,
  output logic            h_rvld,
  output logic [DW-1:0]   h_rd,
  output logic            h_starve,
  output logic [AW-1:0]   dat_a,
  output logic [DW/8-1:0] dat_we,
  output logic [DW-1:0]   dat_wd,
  output logic [DW/8-1:0] dat_re,
  input  logic [DW-1:0]   dat_rd
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  buf_st_t       st_q, st_d;
  req_t          buf_q, buf_d;
  logic          rd_own_q, rd_own_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic c_act;
  logic h_op;
  logic issue;
  logic accept;
  logic cap;

  assign c_act  = (|c_we) | (|c_re);
  assign h_op   = (|h_we) | (|h_re);
  assign issue  = (st_q == FULL) & ~c_act;
  assign h_rdy  = (st_q == EMPTY) | issue;
  assign accept = h_vld & h_rdy;
  // Empty requests are acked but never reach the SRAM
  assign cap    = accept & h_op;

  always_comb begin
    st_d  = st_q;
    buf_d = buf_q;
    unique case (1'b1)
      cap: begin
        st_d  = FULL;
        buf_d = '{a: h_a, we: h_we, wd: h_wd, re: h_re};
      end
      issue & ~cap: st_d = EMPTY;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      issue: cnt_d = '0;
      (st_q == FULL) & ~issue & (cnt_q != CNT_MAX):
        cnt_d = cnt_q + CW'(1);
      default: ;
    endcase
  end

  assign rd_own_d = issue & (|buf_q.re);

  always_comb begin
    dat_a  = buf_q.a;
    dat_wd = buf_q.wd;
    dat_we = '0;
    dat_re = '0;
    unique case (1'b1)
      c_act: begin
        dat_a  = c_a;
        dat_wd = c_wd;
        dat_we = c_we;
        dat_re = c_re;
      end
      issue: begin
        dat_we = buf_q.we;
        dat_re = buf_q.re;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q     <= EMPTY;
      buf_q    <= '0;
      rd_own_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      st_q     <= st_d;
      buf_q    <= buf_d;
      rd_own_q <= rd_own_d;
      cnt_q    <= cnt_d;
    end
  end

  assign c_rd     = dat_rd;
  assign h_rd     = dat_rd;
  assign h_rvld   = rd_own_q;
  assign h_starve = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_dmem_arb.sv
// Bench for dmem_arb: directed vector table, corner sequences,
// and randomized traffic against a queue-level model.
module tb_dmem_arb;
  import dmem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] c_a;
  logic [3:0]  c_we, c_re;
  logic [31:0] c_wd, c_rd;
  logic        h_vld, h_rdy;
  logic [15:0] h_a;
  logic [3:0]  h_we, h_re;
  logic [31:0] h_wd, h_rd;
  logic        h_rvld, h_starve;
  logic [15:0] dat_a;
  logic [3:0]  dat_we, dat_re;
  logic [31:0] dat_wd, dat_rd;

  dmem_arb dut (
    .clk(clk), .rstn(rstn),
    .c_a(c_a), .c_we(c_we), .c_wd(c_wd), .c_re(c_re), .c_rd(c_rd),
    .h_vld(h_vld), .h_rdy(h_rdy), .h_a(h_a), .h_we(h_we),
    .h_wd(h_wd), .h_re(h_re), .h_rvld(h_rvld), .h_rd(h_rd),
    .h_starve(h_starve),
    .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd),
    .dat_re(dat_re), .dat_rd(dat_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  logic [31:0] sram_rd = 32'h0;
  assign dat_rd = sram_rd;

  always @(posedge clk) begin
    if (|dat_re) sram_rd <= mem[dat_a];
    for (int b = 0; b < 4; b++)
      if (dat_we[b]) mem[dat_a][8*b +: 8] <= dat_wd[8*b +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    c_a = 16'h0; c_we = 4'h0; c_re = 4'h0; c_wd = 32'h0;
    h_vld = 1'b0; h_a = 16'h0; h_we = 4'h0; h_re = 4'h0;
    h_wd = 32'h0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o,
                                         input logic [31:0] n,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  typedef struct {
    logic [3:0]  cwe, cre;
    logic [15:0] ca;
    logic [31:0] cwd;
    logic        hv;
    logic [3:0]  hwe, hre;
    logic [15:0] ha;
    logic [31:0] hwd;
    logic        rdy;
    logic [3:0]  dwe, dre;
    logic [15:0] da;
    logic [31:0] dwd;
    logic        rvld;
    logic [31:0] hrd;
    logic        ccrd;
    logic [31:0] crd;
  } vec_t;

  vec_t tbl [14];

  // random-phase model state
  logic        pv;
  req_t        p;
  int          blk;
  logic        erv, ecv;
  logic [31:0] erd, ecrd;
  logic [31:0] gold [16];
  logic        cact, iss, erdy;
  logic        nrv, ncv;
  logic [31:0] nrd, ncrd;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0020] = 32'h11223344;
    idle_in();

    // cmp: core; host: vld we re a wd; exp: rdy dwe dre da dwd; rvld hrd; crd
    tbl[0]  = '{4'h0,4'hF,16'h0010,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'hF,16'h0010,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[1]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b1,4'hF,4'h0,16'h0040,32'h12345678, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b0,32'h0, 1'b1,32'hDEADBEEF};
    tbl[2]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'hF,16'h0040,32'h0, 1'b1,4'hF,4'h0,16'h0040,32'h12345678, 1'b0,32'h0, 1'b0,32'h0};
    tbl[3]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'hF,16'h0040,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[4]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b1,32'h12345678, 1'b0,32'h0};
    tbl[5]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h2,4'h0,16'h0020,32'h0000AB00, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[6]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'hF,16'h0020,32'h0, 1'b1,4'h2,4'h0,16'h0020,32'h0000AB00, 1'b0,32'h0, 1'b0,32'h0};
    tbl[7]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'hF,16'h0020,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[8]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b1,32'h1122AB44, 1'b0,32'h0};
    tbl[9]  = '{4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'h0,16'h0050,32'hFFFFFFFF, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[10] = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[11] = '{4'hF,4'h0,16'h0030,32'hA5A5A5A5, 1'b1,4'h0,4'hF,16'h0030,32'h0, 1'b1,4'hF,4'h0,16'h0030,32'hA5A5A5A5, 1'b0,32'h0, 1'b0,32'h0};
    tbl[12] = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'hF,16'h0030,32'h0, 1'b0,32'h0, 1'b0,32'h0};
    tbl[13] = '{4'h0,4'h0,16'h0000,32'h0, 1'b0,4'h0,4'h0,16'h0000,32'h0, 1'b1,4'h0,4'h0,16'h0,32'h0, 1'b1,32'hA5A5A5A5, 1'b0,32'h0};

    // reset state
    #2;
    chk("rst_h_rdy", 32'(h_rdy), 32'h1);
    chk("rst_h_rvld", 32'(h_rvld), 32'h0);
    chk("rst_h_starve", 32'(h_starve), 32'h0);
    chk("rst_dat_we", 32'(dat_we), 32'h0);
    chk("rst_dat_re", 32'(dat_re), 32'h0);
    next_cyc();
    next_cyc();
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      c_we = tbl[i].cwe; c_re = tbl[i].cre;
      c_a = tbl[i].ca; c_wd = tbl[i].cwd;
      h_vld = tbl[i].hv; h_we = tbl[i].hwe; h_re = tbl[i].hre;
      h_a = tbl[i].ha; h_wd = tbl[i].hwd;
      @(negedge clk);
      chk($sformatf("v%0d_h_rdy", i), 32'(h_rdy), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_dat_we", i), 32'(dat_we), 32'(tbl[i].dwe));
      chk($sformatf("v%0d_dat_re", i), 32'(dat_re), 32'(tbl[i].dre));
      if ((|tbl[i].dwe) || (|tbl[i].dre))
        chk($sformatf("v%0d_dat_a", i), 32'(dat_a), 32'(tbl[i].da));
      if (|tbl[i].dwe)
        chk($sformatf("v%0d_dat_wd", i), dat_wd, tbl[i].dwd);
      chk($sformatf("v%0d_h_rvld", i), 32'(h_rvld), 32'(tbl[i].rvld));
      if (tbl[i].rvld)
        chk($sformatf("v%0d_h_rd", i), h_rd, tbl[i].hrd);
      if (tbl[i].ccrd)
        chk($sformatf("v%0d_c_rd", i), c_rd, tbl[i].crd);
      next_cyc();
    end

    // core blocks a pending host read for 5 cycles
    idle_in();
    h_vld = 1'b1; h_re = 4'hF; h_a = 16'h0040;
    @(negedge clk);
    chk("blk_accept_rdy", 32'(h_rdy), 32'h1);
    next_cyc();
    for (int k = 1; k <= 5; k++) begin
      idle_in();
      c_re = 4'hF; c_a = 16'h0010;
      h_vld = 1'b1; h_re = 4'hF; h_a = 16'h0020;
      @(negedge clk);
      chk($sformatf("blk%0d_h_rdy", k), 32'(h_rdy), 32'h0);
      chk($sformatf("blk%0d_dat_a", k), 32'(dat_a), 32'h0010);
      chk($sformatf("blk%0d_cnt", k), 32'(dut.cnt_q), 32'(k - 1));
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    chk("blk_issue_h_rdy", 32'(h_rdy), 32'h1);
    chk("blk_issue_dat_re", 32'(dat_re), 32'hF);
    chk("blk_issue_dat_a", 32'(dat_a), 32'h0040);
    chk("blk_issue_cnt", 32'(dut.cnt_q), 32'd5);
    next_cyc();
    @(negedge clk);
    chk("blk_h_rvld", 32'(h_rvld), 32'h1);
    chk("blk_h_rd", h_rd, 32'h12345678);
    chk("blk_cnt_clr", 32'(dut.cnt_q), 32'd0);
    next_cyc();

    // starvation: 20 blocked cycles
    idle_in();
    h_vld = 1'b1; h_re = 4'hF; h_a = 16'h0020;
    next_cyc();
    for (int k = 1; k <= 20; k++) begin
      idle_in();
      c_we = 4'h1; c_a = 16'h0100; c_wd = 32'h0;
      @(negedge clk);
      chk($sformatf("stv%0d_h_starve", k), 32'(h_starve),
          32'(k >= 16));
      chk($sformatf("stv%0d_h_rdy", k), 32'(h_rdy), 32'h0);
      next_cyc();
    end
    idle_in();
    @(negedge clk);
    chk("stv_issue_h_starve", 32'(h_starve), 32'h1);
    chk("stv_issue_dat_re", 32'(dat_re), 32'hF);
    next_cyc();
    @(negedge clk);
    chk("stv_clr_h_starve", 32'(h_starve), 32'h0);
    chk("stv_h_rvld", 32'(h_rvld), 32'h1);
    chk("stv_h_rd", h_rd, 32'h1122AB44);
    next_cyc();

    // reset right after a host read issue
    idle_in();
    h_vld = 1'b1; h_re = 4'hF; h_a = 16'h0040;
    next_cyc();
    idle_in();
    @(negedge clk);
    chk("rmid_issue_dat_re", 32'(dat_re), 32'hF);
    next_cyc();
    rstn = 1'b0;
    c_re = 4'hF; c_a = 16'h0010;
    #1;
    chk("rmid_h_rvld", 32'(h_rvld), 32'h0);
    chk("rmid_h_rdy", 32'(h_rdy), 32'h1);
    chk("rmid_h_starve", 32'(h_starve), 32'h0);
    next_cyc();
    rstn = 1'b1;
    @(negedge clk);
    chk("rmid_post_h_rvld", 32'(h_rvld), 32'h0);
    chk("rmid_post_h_rdy", 32'(h_rdy), 32'h1);
    next_cyc();

    // randomized traffic against the queue model
    idle_in();
    rstn = 1'b0;
    next_cyc();
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      gold[i] = 32'hC0DE0000 | 32'(i);
      mem[16'(i)] = gold[i];
    end
    pv = 1'b0; p = '0; blk = 0; erv = 1'b0; ecv = 1'b0;
    erd = 32'h0; ecrd = 32'h0;
    for (int cy = 0; cy < 3000; cy++) begin
      cact = ($urandom_range(0, 99) < 40);
      c_a = 16'($urandom_range(0, 15));
      c_wd = $urandom;
      c_we = cact ? 4'($urandom) : 4'h0;
      c_re = cact ? 4'($urandom) : 4'h0;
      if (cact && c_we == 4'h0 && c_re == 4'h0) c_re = 4'hF;
      h_vld = 1'($urandom);
      h_a = 16'($urandom_range(0, 15));
      h_wd = $urandom;
      h_we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      h_re = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      iss = pv && !cact;
      erdy = !pv || iss;
      @(negedge clk);
      chk("rnd_h_rdy", 32'(h_rdy), 32'(erdy));
      if (cact) begin
        chk("rnd_core_we", 32'(dat_we), 32'(c_we));
        chk("rnd_core_re", 32'(dat_re), 32'(c_re));
        chk("rnd_core_a", 32'(dat_a), 32'(c_a));
        chk("rnd_core_wd", dat_wd, c_wd);
      end else if (iss) begin
        chk("rnd_host_we", 32'(dat_we), 32'(p.we));
        chk("rnd_host_re", 32'(dat_re), 32'(p.re));
        chk("rnd_host_a", 32'(dat_a), 32'(p.a));
        if (|p.we) chk("rnd_host_wd", dat_wd, p.wd);
      end else begin
        chk("rnd_idle_we", 32'(dat_we), 32'h0);
        chk("rnd_idle_re", 32'(dat_re), 32'h0);
      end
      chk("rnd_h_rvld", 32'(h_rvld), 32'(erv));
      if (erv) chk("rnd_h_rd", h_rd, erd);
      if (ecv) chk("rnd_c_rd", c_rd, ecrd);
      chk("rnd_h_starve", 32'(h_starve), 32'(blk >= 15));
      nrv = iss && (|p.re);
      nrd = gold[p.a[3:0]];
      ncv = cact && (|c_re);
      ncrd = gold[c_a[3:0]];
      if (cact)
        gold[c_a[3:0]] = bmerge(gold[c_a[3:0]], c_wd, c_we);
      else if (iss)
        gold[p.a[3:0]] = bmerge(gold[p.a[3:0]], p.wd, p.we);
      if (iss) blk = 0;
      else if (pv) blk++;
      if (h_vld && erdy && ((|h_we) || (|h_re))) begin
        pv = 1'b1;
        p = '{a: h_a, we: h_we, wd: h_wd, re: h_re};
      end else if (iss) begin
        pv = 1'b0;
      end
      erv = nrv; erd = nrd; ecv = ncv; ecrd = ncrd;
      next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
